mem_sync_assoc: RTL and testbench

Parametrised, dirty-aware successor to the row-cache sync FSM. It tracks which emulated DRAM rows currently reside in the on-chip row cache, using a fully-associative tag table of 2**CHWIDTH entries with valid and dirty bits. On ACT it resolves hit or miss, then sequences victim write-back and row allocation with the host memory through a sync handshake. It sits between the DDR command decoder (ACT/RD/WR/PR) and the row-buffer datapath, which it drives via cRowId/wbRowId.

---
 rtl/mem_sync_pkg.sv | 20 ++
 rtl/mem_sync_tagtab.sv | 92 +++++++++
 rtl/mem_sync_assoc.sv | 155 +++++++++++++++
 tb/tb_mem_sync_assoc.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sync_pkg.sv
// Shared types and helpers for the associative row-cache sync controller.
package mem_sync_pkg;

   // FSM states; the encoding is visible on the debug state port.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ALLOC = 3'd1,
      S_CMP   = 3'd2,
      S_UPD   = 3'd3,
      S_WB    = 3'd4,
      S_HITRD = 3'd5,
      S_HITWR = 3'd6
   } state_t;

   // Number of cache entries for a given index width, never less than one.
   function automatic int unsigned chrows(input int unsigned chwidth);
      return (chwidth == 0) ? 32'd1 : (32'd1 << chwidth);
   endfunction

endpackage

// File: rtl/mem_sync_tagtab.sv
// Fully-associative tag table: tags with valid/dirty bits, parallel lookup,
// victim selection (first invalid entry, else round-robin) and dirty marking.
module mem_sync_tagtab
   import mem_sync_pkg::*;
#(
   parameter int CHWIDTH   = 6,
   parameter int ADDRWIDTH = 17
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDRWIDTH-1:0] cmp_row,
   output logic                 hit,
   output logic [CHWIDTH-1:0]   hit_idx,
   output logic [CHWIDTH-1:0]   victim_idx,
   output logic                 victim_valid,
   output logic                 victim_dirty,
   output logic [ADDRWIDTH-1:0] victim_tag,
   input  logic                 alloc,
   input  logic [ADDRWIDTH-1:0] alloc_row,
   input  logic                 dirty_set,
   input  logic [CHWIDTH-1:0]   dirty_idx
);

   localparam int CHROWS = chrows(CHWIDTH);

   logic [ADDRWIDTH-1:0] tags [CHROWS];
   logic [CHROWS-1:0]    valid;
   logic [CHROWS-1:0]    dirty;
   logic [CHWIDTH-1:0]   rr_ptr;
   logic [CHWIDTH-1:0]   free_idx;
   logic                 free_found;

   // Parallel compare of the activated row against every valid tag.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < CHROWS; i++) begin
         if (!hit && valid[i] && (tags[i] == cmp_row)) begin
            hit     = 1'b1;
            hit_idx = CHWIDTH'(i);
         end
      end
   end

   // Priority encoder for the lowest-index invalid entry.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = 0; i < CHROWS; i++) begin
         if (!free_found && !valid[i]) begin
            free_found = 1'b1;
            free_idx   = CHWIDTH'(i);
         end
      end
   end

   // Victim: a free slot if any, otherwise the round-robin pointer.
   always_comb begin
      victim_idx   = free_found ? free_idx : rr_ptr;
      victim_valid = valid[victim_idx];
      victim_dirty = dirty[victim_idx];
      victim_tag   = tags[victim_idx];
   end

   // Valid/dirty bookkeeping and round-robin advance (only when the table is full).
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid  <= '0;
         dirty  <= '0;
         rr_ptr <= '0;
      end else begin
         if (dirty_set) begin
            dirty[dirty_idx] <= 1'b1;
         end
         if (alloc) begin
            valid[victim_idx] <= 1'b1;
            dirty[victim_idx] <= 1'b0;
            if (!free_found) begin
               rr_ptr <= rr_ptr + CHWIDTH'(1);
            end
         end
      end
   end

   // Tag storage is not cleared by reset; valid bits gate every use.
   always_ff @(posedge clk) begin
      if (alloc) begin
         tags[victim_idx] <= alloc_row;
      end
   end

endmodule

// File: rtl/mem_sync_assoc.sv
// Row-cache sync controller: resolves ACT hit/miss against the tag table,
// sequences victim write-back and allocation with the host via sync, and
// keeps saturating hit/miss/write-back statistics.
module mem_sync_assoc
   import mem_sync_pkg::*;
#(
   parameter int CHWIDTH   = 6,
   parameter int ADDRWIDTH = 17,
   parameter int WB_ALWAYS = 0,
   parameter int CNTWIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ACT,
   input  logic                 RD,
   input  logic                 WR,
   input  logic                 PR,
   input  logic [ADDRWIDTH-1:0] RowId,
   input  logic                 sync,
   output logic [CHWIDTH-1:0]   cRowId,
   output logic [ADDRWIDTH-1:0] wbRowId,
   output logic                 stall,
   output logic [2:0]           state,
   output logic [CNTWIDTH-1:0]  hit_cnt,
   output logic [CNTWIDTH-1:0]  miss_cnt,
   output logic [CNTWIDTH-1:0]  wb_cnt
);

   state_t               cur;
   state_t               nxt;
   logic [ADDRWIDTH-1:0] act_row;
   logic                 first_cmp;
   logic                 stall_nxt;
   logic                 alloc;
   logic                 need_wb;
   logic                 dirty_set;

   logic                 hit;
   logic [CHWIDTH-1:0]   hit_idx;
   logic [CHWIDTH-1:0]   victim_idx;
   logic                 victim_valid;
   logic                 victim_dirty;
   logic [ADDRWIDTH-1:0] victim_tag;

   function automatic logic [CNTWIDTH-1:0] sat_inc(input logic [CNTWIDTH-1:0] v);
      return (&v) ? v : v + CNTWIDTH'(1);
   endfunction

   mem_sync_tagtab #(
      .CHWIDTH   (CHWIDTH),
      .ADDRWIDTH (ADDRWIDTH)
   ) u_tagtab (
      .clk          (clk),
      .rst          (rst),
      .cmp_row      (act_row),
      .hit          (hit),
      .hit_idx      (hit_idx),
      .victim_idx   (victim_idx),
      .victim_valid (victim_valid),
      .victim_dirty (victim_dirty),
      .victim_tag   (victim_tag),
      .alloc        (alloc),
      .alloc_row    (act_row),
      .dirty_set    (dirty_set),
      .dirty_idx    (cRowId)
   );

   // State register; stall is registered alongside so it tracks state exactly.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cur   <= S_IDLE;
         stall <= 1'b0;
      end else begin
         cur   <= nxt;
         stall <= stall_nxt;
      end
   end

   // Next-state logic; PR beats WR beats RD wherever they compete.
   always_comb begin
      nxt = cur;
      case (cur)
         S_IDLE:  if (ACT) nxt = S_CMP;
         S_CMP: begin
            if (!hit)    nxt = S_UPD;
            else if (PR) nxt = S_IDLE;
            else if (WR) nxt = S_HITWR;
            else if (RD) nxt = S_HITRD;
         end
         S_UPD:   nxt = need_wb ? S_WB : S_ALLOC;
         S_WB:    if (sync) nxt = S_ALLOC;
         S_ALLOC: if (sync) nxt = S_CMP;
         S_HITRD: begin
            if (PR)       nxt = S_IDLE;
            else if (!RD) nxt = S_CMP;
         end
         S_HITWR: begin
            if (PR)       nxt = S_IDLE;
            else if (!WR) nxt = S_CMP;
         end
         default: nxt = S_IDLE;
      endcase
   end

   // Output decode: table control strobes and next-cycle stall.
   always_comb begin
      alloc     = (cur == S_UPD);
      need_wb   = victim_valid && (victim_dirty || (WB_ALWAYS != 0));
      dirty_set = (cur == S_HITWR);
      stall_nxt = (nxt == S_UPD) || (nxt == S_WB) || (nxt == S_ALLOC);
   end

   // Registered row indices and statistics; counting happens once per ACT.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cRowId    <= '0;
         wbRowId   <= '0;
         hit_cnt   <= '0;
         miss_cnt  <= '0;
         wb_cnt    <= '0;
         first_cmp <= 1'b0;
      end else begin
         if ((cur == S_IDLE) && ACT) begin
            first_cmp <= 1'b1;
         end
         if (cur == S_CMP) begin
            first_cmp <= 1'b0;
            if (first_cmp) begin
               if (hit) hit_cnt  <= sat_inc(hit_cnt);
               else     miss_cnt <= sat_inc(miss_cnt);
            end
            if (hit) begin
               cRowId <= hit_idx;
            end
         end
         if (cur == S_UPD) begin
            cRowId <= victim_idx;
            if (need_wb) begin
               wbRowId <= victim_tag;
               wb_cnt  <= sat_inc(wb_cnt);
            end
         end
      end
   end

   // Activated row address, captured only when an ACT is accepted.
   always_ff @(posedge clk) begin
      if ((cur == S_IDLE) && ACT) begin
         act_row <= RowId;
      end
   end

   assign state = cur;

endmodule

// File: tb/tb_mem_sync_assoc.sv
// Bench for mem_sync_assoc: two 4-entry instances (dirty-only and legacy
// write-back with 3-bit counters) checked against a table-level model.
module tb_mem_sync_assoc;

   logic        clk = 1'b0;
   logic        rst_n  [2];
   logic        act    [2];
   logic        rd     [2];
   logic        wr     [2];
   logic        pr     [2];
   logic        sync_i [2];
   logic [16:0] rowid  [2];
   logic [1:0]  crow   [2];
   logic [16:0] wbrow  [2];
   logic        stl    [2];
   logic [2:0]  st     [2];
   logic [31:0] hc0, mc0, wc0;
   logic [2:0]  hc1, mc1, wc1;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: entry contents and expected counters per instance.
   logic [16:0] m_tag   [2][4];
   bit          m_val   [2][4];
   bit          m_dirty [2][4];
   int          m_rr    [2];
   int          m_cnt   [2][3];
   int          m_cur   [2];

   always #5 clk = ~clk;

   mem_sync_assoc #(.CHWIDTH(2), .ADDRWIDTH(17), .WB_ALWAYS(0), .CNTWIDTH(32)) dut0 (
      .clk(clk), .rst(rst_n[0]), .ACT(act[0]), .RD(rd[0]), .WR(wr[0]), .PR(pr[0]),
      .RowId(rowid[0]), .sync(sync_i[0]), .cRowId(crow[0]), .wbRowId(wbrow[0]),
      .stall(stl[0]), .state(st[0]), .hit_cnt(hc0), .miss_cnt(mc0), .wb_cnt(wc0));

   mem_sync_assoc #(.CHWIDTH(2), .ADDRWIDTH(17), .WB_ALWAYS(1), .CNTWIDTH(3)) dut1 (
      .clk(clk), .rst(rst_n[1]), .ACT(act[1]), .RD(rd[1]), .WR(wr[1]), .PR(pr[1]),
      .RowId(rowid[1]), .sync(sync_i[1]), .cRowId(crow[1]), .wbRowId(wbrow[1]),
      .stall(stl[1]), .state(st[1]), .hit_cnt(hc1), .miss_cnt(mc1), .wb_cnt(wc1));

   initial begin
      #500000;
      $display("FAIL watchdog: observed no completion, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] gcnt(input int u, input int k);
      if (u == 0) return (k == 0) ? hc0 : (k == 1) ? mc0 : wc0;
      return {29'd0, (k == 0) ? hc1 : (k == 1) ? mc1 : wc1};
   endfunction

   function automatic int sat(input int u, input int v);
      return (u == 1 && v > 7) ? 7 : v;
   endfunction

   function automatic bit lookup(input int u, input logic [16:0] row, output int idx);
      idx = 0;
      for (int i = 0; i < 4; i++)
         if (m_val[u][i] && m_tag[u][i] == row) begin
            idx = i;
            return 1'b1;
         end
      return 1'b0;
   endfunction

   task automatic model_reset(input int u);
      for (int i = 0; i < 4; i++) begin
         m_val[u][i]   = 1'b0;
         m_dirty[u][i] = 1'b0;
      end
      m_rr[u] = 0;
      for (int k = 0; k < 3; k++) m_cnt[u][k] = 0;
      m_cur[u] = 0;
   endtask

   // ACT a row and follow it until it is open in CompareTag with a hit.
   task automatic open_row(input int u, input logic [16:0] row);
      int idx, v, w;
      bit h, need;
      logic [16:0] old;
      act[u] = 1'b1; rowid[u] = row;
      tick();
      act[u] = 1'b0;
      check("act_to_cmp", 32'(st[u]), 32'd2);
      h = lookup(u, row, idx);
      tick();
      if (h) begin
         m_cnt[u][0] = sat(u, m_cnt[u][0] + 1);
         check("hit_state", 32'(st[u]), 32'd2);
         check("hit_cnt", gcnt(u, 0), 32'(m_cnt[u][0]));
         check("hit_idx", 32'(crow[u]), 32'(idx));
         m_cur[u] = idx;
      end else begin
         m_cnt[u][1] = sat(u, m_cnt[u][1] + 1);
         v = -1;
         for (int i = 0; i < 4; i++) if (v < 0 && !m_val[u][i]) v = i;
         if (v < 0) begin v = m_rr[u]; m_rr[u] = (m_rr[u] + 1) % 4; end
         need = m_val[u][v] && (m_dirty[u][v] || u == 1);
         old  = m_tag[u][v];
         m_tag[u][v] = row; m_val[u][v] = 1'b1; m_dirty[u][v] = 1'b0;
         m_cur[u] = v;
         check("miss_upd_state", 32'(st[u]), 32'd3);
         check("miss_upd_stall", 32'(stl[u]), 32'd1);
         check("miss_cnt", gcnt(u, 1), 32'(m_cnt[u][1]));
         tick();
         if (need) begin
            m_cnt[u][2] = sat(u, m_cnt[u][2] + 1);
            check("wb_state", 32'(st[u]), 32'd4);
            check("wb_row", 32'(wbrow[u]), 32'(old));
            check("wb_cnt", gcnt(u, 2), 32'(m_cnt[u][2]));
            w = $urandom_range(0, 2);
            repeat (w) begin tick(); check("wb_hold", 32'(st[u]), 32'd4); end
            sync_i[u] = 1'b1; tick(); sync_i[u] = 1'b0;
         end
         check("alloc_state", 32'(st[u]), 32'd1);
         check("alloc_stall", 32'(stl[u]), 32'd1);
         check("victim_idx", 32'(crow[u]), 32'(v));
         check("wb_cnt_alloc", gcnt(u, 2), 32'(m_cnt[u][2]));
         w = $urandom_range(0, 2);
         repeat (w) begin tick(); check("alloc_hold", 32'(st[u]), 32'd1); end
         sync_i[u] = 1'b1; tick(); sync_i[u] = 1'b0;
         check("reenter_cmp", 32'(st[u]), 32'd2);
         check("reenter_stall", 32'(stl[u]), 32'd0);
         tick();
         check("reenter_hit", 32'(st[u]), 32'd2);
         check("reenter_nocount", gcnt(u, 0) + gcnt(u, 1),
               32'(m_cnt[u][0] + m_cnt[u][1]));
         check("reenter_idx", 32'(crow[u]), 32'(v));
      end
   endtask

   // Drive one command cycle and check the resulting state.
   task automatic step(input int u, input bit p, input bit w, input bit r,
                       input logic [2:0] exp, input string tag);
      pr[u] = p; wr[u] = w; rd[u] = r;
      tick();
      pr[u] = 1'b0; wr[u] = 1'b0; rd[u] = 1'b0;
      check(tag, 32'(st[u]), 32'(exp));
      if (exp == 3'd6) m_dirty[u][m_cur[u]] = 1'b1;
   endtask

   initial begin
      for (int u = 0; u < 2; u++) begin
         rst_n[u] = 1'b0; act[u] = 1'b0; rd[u] = 1'b0; wr[u] = 1'b0;
         pr[u] = 1'b0; sync_i[u] = 1'b0; rowid[u] = '0;
         model_reset(u);
      end
      tick(); tick();
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;
      tick();
      for (int u = 0; u < 2; u++) begin
         check("rst_state", 32'(st[u]), 32'd0);
         check("rst_stall", 32'(stl[u]), 32'd0);
         check("rst_crow", 32'(crow[u]), 32'd0);
         check("rst_wbrow", 32'(wbrow[u]), 32'd0);
         for (int k = 0; k < 3; k++) check("rst_cnt", gcnt(u, k), 32'd0);
      end

      // Cold fill, then a clean eviction of entry 0.
      for (int i = 0; i < 4; i++) begin
         open_row(0, 17'h10 + 17'(i));
         check("fill_idx", 32'(crow[0]), 32'(i));
         step(0, 1, 0, 0, 3'd0, "fill_pr");
      end
      check("fill_miss", mc0, 32'd4);
      check("fill_wb", wc0, 32'd0);
      open_row(0, 17'h14);
      check("clean_victim", 32'(crow[0]), 32'd0);
      check("clean_wb", wc0, 32'd0);
      step(0, 1, 0, 0, 3'd0, "clean_pr");

      // Dirty eviction of row 0x11 at entry 1.
      open_row(0, 17'h11);
      step(0, 0, 1, 0, 3'd6, "dirty_wr");
      step(0, 1, 0, 0, 3'd0, "dirty_pr");
      open_row(0, 17'h15);
      check("dirty_wbrow", 32'(wbrow[0]), 32'h11);
      check("dirty_wbcnt", wc0, 32'd1);
      check("dirty_idx", 32'(crow[0]), 32'd1);
      step(0, 1, 0, 0, 3'd0, "dirty_close");

      // Hit paths and command priority.
      open_row(0, 17'h12);
      check("hit_row_idx", 32'(crow[0]), 32'd2);
      step(0, 0, 0, 1, 3'd5, "hit_rd");
      step(0, 1, 0, 1, 3'd0, "rd_pr_prio");
      open_row(0, 17'h12);
      step(0, 0, 1, 1, 3'd6, "wr_over_rd");
      step(0, 0, 1, 0, 3'd6, "wr_hold");
      step(0, 1, 0, 0, 3'd0, "wr_close");
      open_row(0, 17'h12);
      step(0, 1, 1, 0, 3'd0, "pr_over_wr");
      open_row(0, 17'h13);
      step(0, 0, 0, 1, 3'd5, "rd_again");
      step(0, 0, 0, 0, 3'd2, "rd_release");
      step(0, 1, 0, 0, 3'd0, "rd_release_pr");

      // Randomized traffic over six rows competing for four entries.
      for (int it = 0; it < 30; it++) begin
         logic [16:0] r;
         int op, n;
         r  = 17'h20 + 17'($urandom_range(0, 5));
         op = $urandom_range(0, 2);
         n  = $urandom_range(0, 2);
         open_row(0, r);
         if (op == 0) begin
            step(0, 0, 0, 1, 3'd5, "rnd_rd");
            repeat (n) step(0, 0, 0, 1, 3'd5, "rnd_rd_hold");
            step(0, 1, 0, 0, 3'd0, "rnd_rd_pr");
         end else if (op == 1) begin
            step(0, 0, 1, 0, 3'd6, "rnd_wr");
            repeat (n) step(0, 0, 1, 0, 3'd6, "rnd_wr_hold");
            step(0, 1, 0, 0, 3'd0, "rnd_wr_pr");
         end else begin
            step(0, 1, 0, 0, 3'd0, "rnd_pr");
         end
         check("rnd_idle_stall", 32'(stl[0]), 32'd0);
      end
      for (int k = 0; k < 3; k++) check("rnd_cnt", gcnt(0, k), 32'(m_cnt[0][k]));

      // Legacy write-back of a clean victim, interrupted by reset.
      for (int i = 0; i < 4; i++) begin
         open_row(1, 17'h10 + 17'(i));
         step(1, 1, 0, 0, 3'd0, "lfill_pr");
      end
      act[1] = 1'b1; rowid[1] = 17'h14;
      tick();
      act[1] = 1'b0;
      check("leg_cmp", 32'(st[1]), 32'd2);
      tick();
      check("leg_upd", 32'(st[1]), 32'd3);
      tick();
      check("leg_wb_state", 32'(st[1]), 32'd4);
      check("leg_wb_cnt", 32'(wc1), 32'd1);
      check("leg_wb_row", 32'(wbrow[1]), 32'h10);
      rst_n[1] = 1'b0;
      tick();
      rst_n[1] = 1'b1;
      model_reset(1);
      check("mrst_state", 32'(st[1]), 32'd0);
      check("mrst_stall", 32'(stl[1]), 32'd0);
      check("mrst_wbrow", 32'(wbrow[1]), 32'd0);
      for (int k = 0; k < 3; k++) check("mrst_cnt", gcnt(1, k), 32'd0);
      open_row(1, 17'h10);
      check("mrst_miss", 32'(mc1), 32'd1);
      check("mrst_hit", 32'(hc1), 32'd0);
      check("mrst_wb", 32'(wc1), 32'd0);
      step(1, 1, 0, 0, 3'd0, "mrst_pr");

      // Counter saturation on the 3-bit instance.
      for (int i = 0; i < 12; i++) begin
         open_row(1, 17'h40 + 17'(i));
         step(1, 1, 0, 0, 3'd0, "sat_pr");
      end
      check("sat_miss", 32'(mc1), 32'd7);
      check("sat_wb", 32'(wc1), 32'd7);
      check("sat_hit", 32'(hc1), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
